hall_call_scheduler: RTL and testbench

- Receiving end of the hall-button call interface. Consumes the encoded call (floor_call, up_down_flag, plus a valid strobe) produced by the button encoder.
- Latches pending hall calls and drives the six button lamps.
- Picks the next target floor using a SCAN (sweep) policy and hands it to the car motion controller with a valid/ready handshake.
- Clears each call when the car reports arrival.

---
 rtl/hall_call_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_hall_call_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_scheduler.sv
// hall_call_scheduler
//   Latches encoded hall calls, drives the six hall-button lamps, and picks
//   the next target floor with a SCAN (sweep) policy. The chosen target is
//   offered to the motion controller over a valid/ready handshake. The
//   matching lamp is cleared once the car reports arrival.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   call_valid      one-cycle strobe qualifying floor_call / up_down_flag
//   floor_call      calling floor 0..3
//   up_down_flag    1 = up call, 0 = down call
//   car_floor       current car floor 0..3
//   car_idle        car stopped and ready for a new target
//   target_ready    motion controller accepts the offered target
//   arrive          one-cycle pulse: car stopped at the accepted target
//   target_valid    target_floor / target_dir are offered
//   target_floor    selected floor
//   target_dir      direction of the selected call, 1 = up
//   lamps           pending calls: [0] 1U, [1] 2D, [2] 2U, [3] 3D, [4] 3U, [5] 4D
//   busy            high in every state except IDLE
module hall_call_scheduler (
  input  logic       clk,
  input  logic       rst,
  input  logic       call_valid,
  input  logic [1:0] floor_call,
  input  logic       up_down_flag,
  input  logic [1:0] car_floor,
  input  logic       car_idle,
  input  logic       target_ready,
  input  logic       arrive,
  output logic       target_valid,
  output logic [1:0] target_floor,
  output logic       target_dir,
  output logic [5:0] lamps,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    DISPATCH,
    WAIT_ARRIVE,
    CLEAR
  } state_t;

  state_t     state;
  logic       sweep_up;
  logic [5:0] set_mask;
  logic [5:0] clr_mask;
  logic [3:0] up_pend;
  logic [3:0] dn_pend;
  logic [1:0] sel_floor;
  logic       sel_dir;

  // One-hot lamp mask for a (floor, direction) pair. Floor 0 down and
  // floor 3 up have no button and map to an empty mask.
  function automatic logic [5:0] call_mask(input logic [1:0] fl, input logic up);
    logic [5:0] m;
    m = '0;
    case ({fl, up})
      3'b001:  m[0] = 1'b1;
      3'b010:  m[1] = 1'b1;
      3'b011:  m[2] = 1'b1;
      3'b100:  m[3] = 1'b1;
      3'b101:  m[4] = 1'b1;
      3'b110:  m[5] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

  always_comb begin
    set_mask = call_valid ? call_mask(floor_call, up_down_flag) : '0;
    clr_mask = (state == CLEAR) ? call_mask(target_floor, target_dir) : '0;
  end

  // Per-floor pending views, indexed by floor number. Floor 3 has no up
  // button and floor 0 has no down button; those slots are tied to 0.
  always_comb begin
    up_pend = {1'b0, lamps[4], lamps[2], lamps[0]};
    dn_pend = {lamps[5], lamps[3], lamps[1], 1'b0};
  end

  // SCAN priority: first pending call in the sweep-ordered list wins.
  always_comb begin
    logic       found;
    logic [1:0] i;
    found     = 1'b0;
    i         = '0;
    sel_floor = '0;
    sel_dir   = 1'b1;
    if (sweep_up) begin
      for (int unsigned k = 0; k < 3; k++) begin
        i = 2'(k);
        if (!found && i >= car_floor && up_pend[i]) begin
          found = 1'b1; sel_floor = i; sel_dir = 1'b1;
        end
      end
      for (int unsigned k = 0; k < 3; k++) begin
        i = 2'(3 - k);
        if (!found && dn_pend[i]) begin
          found = 1'b1; sel_floor = i; sel_dir = 1'b0;
        end
      end
      for (int unsigned k = 0; k < 3; k++) begin
        i = 2'(k);
        if (!found && i < car_floor && up_pend[i]) begin
          found = 1'b1; sel_floor = i; sel_dir = 1'b1;
        end
      end
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        i = 2'(3 - k);
        if (!found && i <= car_floor && dn_pend[i]) begin
          found = 1'b1; sel_floor = i; sel_dir = 1'b0;
        end
      end
      for (int unsigned k = 0; k < 3; k++) begin
        i = 2'(k);
        if (!found && up_pend[i]) begin
          found = 1'b1; sel_floor = i; sel_dir = 1'b1;
        end
      end
      for (int unsigned k = 0; k < 3; k++) begin
        i = 2'(3 - k);
        if (!found && i > car_floor && dn_pend[i]) begin
          found = 1'b1; sel_floor = i; sel_dir = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sweep_up     <= 1'b1;
      lamps        <= '0;
      target_valid <= 1'b0;
      target_floor <= '0;
      target_dir   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // Clear is applied after set, so a re-press during CLEAR is dropped.
      lamps <= (lamps | set_mask) & ~clr_mask;
      case (state)
        IDLE: begin
          if (lamps != '0 && car_idle) begin
            state <= SELECT;
            busy  <= 1'b1;
          end
        end
        SELECT: begin
          target_floor <= sel_floor;
          target_dir   <= sel_dir;
          sweep_up     <= sel_dir;
          target_valid <= 1'b1;
          state        <= DISPATCH;
        end
        DISPATCH: begin
          if (target_ready) begin
            target_valid <= 1'b0;
            state        <= WAIT_ARRIVE;
          end
        end
        WAIT_ARRIVE: begin
          if (arrive) state <= CLEAR;
        end
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          target_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hall_call_scheduler.sv
// tb_hall_call_scheduler
//   Self-checking bench for hall_call_scheduler: a capture vector table,
//   hand-written multi-cycle sequences, and randomized call traffic checked
//   against a cost-based SCAN reference model.
module tb_hall_call_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       call_valid = 1'b0;
  logic [1:0] floor_call = '0;
  logic       up_down_flag = 1'b0;
  logic [1:0] car_floor = '0;
  logic       car_idle = 1'b0;
  logic       target_ready = 1'b0;
  logic       arrive = 1'b0;
  logic       target_valid;
  logic [1:0] target_floor;
  logic       target_dir;
  logic [5:0] lamps;
  logic       busy;

  int checks = 0;
  int failures = 0;

  // Reference model: pending calls by [floor][up] and current sweep.
  bit pend[4][2];
  bit model_sweep_up;

  hall_call_scheduler dut (
    .clk(clk),
    .rst(rst),
    .call_valid(call_valid),
    .floor_call(floor_call),
    .up_down_flag(up_down_flag),
    .car_floor(car_floor),
    .car_idle(car_idle),
    .target_ready(target_ready),
    .arrive(arrive),
    .target_valid(target_valid),
    .target_floor(target_floor),
    .target_dir(target_dir),
    .lamps(lamps),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] fl;
    logic       up;
    logic       idle;
    logic [5:0] exp_lamps;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit valid_call(input int fl, input bit up);
    return !(fl == 0 && !up) && !(fl == 3 && up);
  endfunction

  function automatic logic [5:0] model_mask();
    logic [5:0] m;
    m = '0;
    for (int fl = 0; fl < 4; fl++)
      for (int u = 0; u < 2; u++)
        if (pend[fl][u]) m = m | (6'b1 << (u == 1 ? 2 * fl : 2 * fl - 1));
    return m;
  endfunction

  // Stops on a circular track: up lane floors 0,1,2 at positions 0..2,
  // then down lane floors 3,2,1 at positions 3..5. The winner is the
  // pending stop reached first going forward from the car's position.
  task automatic model_pick(input int f, output int pf, output bit pd);
    int best;
    int car_pos;
    int pos;
    int cost;
    best = 99;
    pf = 0;
    pd = 1'b1;
    car_pos = model_sweep_up ? f : (6 - f) % 6;
    for (int fl = 0; fl < 4; fl++)
      for (int u = 0; u < 2; u++)
        if (pend[fl][u]) begin
          pos = (u == 1) ? fl : 6 - fl;
          cost = (pos - car_pos + 6) % 6;
          if (cost < best) begin
            best = cost;
            pf = fl;
            pd = bit'(u);
          end
        end
  endtask

  task automatic press(input int fl, input bit up);
    call_valid = 1'b1;
    floor_call = 2'(fl);
    up_down_flag = up;
    if (valid_call(fl, up)) pend[fl][up] = 1'b1;
    tick();
    call_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    call_valid = 1'b0;
    target_ready = 1'b0;
    arrive = 1'b0;
    for (int fl = 0; fl < 4; fl++) begin
      pend[fl][0] = 1'b0;
      pend[fl][1] = 1'b0;
    end
    model_sweep_up = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Acts as the motion controller for one target.
  task automatic serve(input int rdelay, input int adelay, input bit inject,
                       output int f, output bit d, output bit ok);
    ok = 1'b0;
    f = 0;
    d = 1'b0;
    for (int c = 0; c < 20 && target_valid !== 1'b1; c++) tick();
    if (target_valid !== 1'b1) begin
      check("dispatch_timeout", 32'(target_valid), 1);
      return;
    end
    ok = 1'b1;
    f = int'(target_floor);
    d = target_dir;
    for (int c = 0; c < rdelay; c++) begin
      tick();
      check("hold_valid", 32'(target_valid), 1);
      check("hold_target", {target_floor, target_dir}, {2'(f), d});
    end
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    check("valid_drop", 32'(target_valid), 0);
    check("busy_wait", 32'(busy), 1);
    for (int c = 0; c < adelay; c++) begin
      if (inject && $urandom_range(0, 1) == 1)
        press(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      else
        tick();
    end
    arrive = 1'b1;
    car_floor = 2'(f);
    tick();
    arrive = 1'b0;
    tick();
    pend[f][d] = 1'b0;
    check("lamps_after_clear", 32'(lamps), 32'(model_mask()));
  endtask

  initial begin
    vec_t vecs[9];
    int   exp_f[4];
    bit   exp_d[4];
    int   gf;
    bit   gd;
    bit   ok;
    int   ef;
    bit   ed;
    int   guard;

    vecs[0] = '{fl: 2'd0, up: 1'b0, idle: 1'b1, exp_lamps: 6'b000000};
    vecs[1] = '{fl: 2'd3, up: 1'b1, idle: 1'b1, exp_lamps: 6'b000000};
    vecs[2] = '{fl: 2'd2, up: 1'b1, idle: 1'b0, exp_lamps: 6'b010000};
    vecs[3] = '{fl: 2'd2, up: 1'b1, idle: 1'b0, exp_lamps: 6'b010000};
    vecs[4] = '{fl: 2'd0, up: 1'b1, idle: 1'b0, exp_lamps: 6'b010001};
    vecs[5] = '{fl: 2'd3, up: 1'b0, idle: 1'b0, exp_lamps: 6'b110001};
    vecs[6] = '{fl: 2'd1, up: 1'b0, idle: 1'b0, exp_lamps: 6'b110011};
    vecs[7] = '{fl: 2'd1, up: 1'b1, idle: 1'b0, exp_lamps: 6'b110111};
    vecs[8] = '{fl: 2'd2, up: 1'b0, idle: 1'b0, exp_lamps: 6'b111111};
    exp_f = '{2, 3, 1, 0};
    exp_d = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values.
    #1;
    check("reset_lamps", 32'(lamps), 0);
    check("reset_valid", 32'(target_valid), 0);
    check("reset_busy", 32'(busy), 0);
    check("reset_target", {target_floor, target_dir}, 0);
    do_reset();

    // Call capture vectors, including invalid and repeated presses.
    for (int v = 0; v < 9; v++) begin
      car_idle = vecs[v].idle;
      press(int'(vecs[v].fl), vecs[v].up);
      check("vec_lamps", 32'(lamps), 32'(vecs[v].exp_lamps));
      tick();
      check("vec_idle", 32'(busy), 0);
    end

    // Asynchronous reset while a target is offered.
    do_reset();
    car_floor = 2'd0;
    car_idle = 1'b1;
    press(1, 1'b1);
    tick();
    tick();
    check("pre_async_valid", 32'(target_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_lamps", 32'(lamps), 0);
    check("async_valid", 32'(target_valid), 0);
    check("async_busy", 32'(busy), 0);
    do_reset();

    // Single call with latency check.
    car_floor = 2'd0;
    car_idle = 1'b1;
    target_ready = 1'b1;
    press(2, 1'b1);
    check("single_lamps", 32'(lamps), 32'(6'b010000));
    tick();
    check("single_busy", 32'(busy), 1);
    tick();
    check("single_valid", 32'(target_valid), 1);
    check("single_target", {target_floor, target_dir}, {2'd2, 1'b1});
    tick();
    check("single_accept", 32'(target_valid), 0);
    target_ready = 1'b0;
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    check("single_cleared", 32'(lamps), 0);
    check("single_idle", 32'(busy), 0);

    // SCAN ordering from floor 1, sweeping up.
    do_reset();
    car_idle = 1'b0;
    car_floor = 2'd1;
    press(0, 1'b1);
    press(1, 1'b0);
    press(2, 1'b1);
    press(3, 1'b0);
    check("scan_lamps", 32'(lamps), 32'(6'b110011));
    car_idle = 1'b1;
    for (int s = 0; s < 4; s++) begin
      serve(0, 1, 1'b0, gf, gd, ok);
      if (ok) check("scan_order", {2'(gf), gd}, {2'(exp_f[s]), exp_d[s]});
    end

    // Handshake hold with a new call arriving during DISPATCH, then a
    // re-press of the same button in the CLEAR cycle.
    do_reset();
    car_floor = 2'd0;
    car_idle = 1'b1;
    press(1, 1'b1);
    tick();
    tick();
    check("hold_first", {target_valid, target_floor, target_dir}, {1'b1, 2'd1, 1'b1});
    for (int c = 0; c < 5; c++) begin
      if (c == 1) press(3, 1'b0);
      else tick();
      check("hold_stable", {target_valid, target_floor, target_dir}, {1'b1, 2'd1, 1'b1});
    end
    check("hold_lamps", 32'(lamps), 32'(6'b100100));
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    arrive = 1'b1;
    car_floor = 2'd1;
    tick();
    arrive = 1'b0;
    tick();
    check("hold_cleared", 32'(lamps), 32'(6'b100000));
    for (int c = 0; c < 20 && target_valid !== 1'b1; c++) tick();
    check("next_target", {target_valid, target_floor, target_dir}, {1'b1, 2'd3, 1'b0});
    target_ready = 1'b1;
    tick();
    target_ready = 1'b0;
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    car_idle = 1'b0;
    call_valid = 1'b1;
    floor_call = 2'd3;
    up_down_flag = 1'b0;
    tick();
    call_valid = 1'b0;
    check("collision_clear", 32'(lamps), 0);
    check("collision_idle", 32'(busy), 0);

    // Reset during WAIT_ARRIVE; a later arrive must do nothing.
    do_reset();
    car_floor = 2'd0;
    car_idle = 1'b1;
    target_ready = 1'b1;
    press(2, 1'b1);
    tick();
    tick();
    tick();
    check("wa_busy", 32'(busy), 1);
    check("wa_valid", 32'(target_valid), 0);
    target_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("wa_reset_out", {lamps, target_valid, target_floor, target_dir, busy}, 0);
    tick();
    rst = 1'b0;
    car_idle = 1'b0;
    arrive = 1'b1;
    tick();
    arrive = 1'b0;
    tick();
    check("wa_after_arrive", {lamps, target_valid, busy}, 0);

    // Randomized traffic against the reference model.
    do_reset();
    for (int r = 0; r < 20; r++) begin
      car_idle = 1'b0;
      car_floor = 2'($urandom_range(0, 3));
      for (int n = 0; n < int'($urandom_range(1, 5)); n++)
        press(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      check("rand_lamps", 32'(lamps), 32'(model_mask()));
      car_idle = 1'b1;
      guard = 0;
      while (model_mask() != '0 && guard < 16) begin
        guard++;
        model_pick(int'(car_floor), ef, ed);
        serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b1, gf, gd, ok);
        if (!ok) break;
        check("rand_target", {2'(gf), gd}, {2'(ef), ed});
        model_sweep_up = ed;
      end
      car_idle = 1'b0;
      tick();
      check("rand_drain", {lamps, busy}, {model_mask(), 1'b0});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
